// File: rtl/mul_div_unit_pkg.sv
// Shared opcode, state and helper definitions for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int W_OPCODE = 6;
  localparam int W_MDU_ST = 2;

  localparam logic [W_OPCODE-1:0] F_MTHI  = 6'h11;
  localparam logic [W_OPCODE-1:0] F_MTLO  = 6'h13;
  localparam logic [W_OPCODE-1:0] F_MULT  = 6'h18;
  localparam logic [W_OPCODE-1:0] F_MULTU = 6'h19;
  localparam logic [W_OPCODE-1:0] F_DIV   = 6'h1A;
  localparam logic [W_OPCODE-1:0] F_DIVU  = 6'h1B;

  typedef enum logic [W_MDU_ST-1:0] {
    MDU_IDLE = 2'd0,
    MDU_PREP = 2'd1,
    MDU_RUN  = 2'd2,
    MDU_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_muldiv(input logic [W_OPCODE-1:0] op);
    return (op == F_MULT) || (op == F_MULTU) || (op == F_DIV) || (op == F_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem_in[W-1:0], bit_in};
  assign diff    = shifted - {1'b0, divisor};
  // rem_in[W] stands for a trial value of 2^(W+1) and above, which always fits
  assign q_bit   = rem_in[W] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO; one result bit per clock.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W_OPCODE-1:0] op,
  input  logic [W-1:0]        A,
  input  logic [W-1:0]        B,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        hi,
  output logic [W-1:0]        lo
);

  localparam int CW = $clog2(W);

  mdu_state_t     state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   opa, opb, quo;
  logic [2*W-1:0] prod;
  logic [W:0]     rem;
  logic           is_div, is_sgn, neg_q, neg_r, dz;

  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     step_rem;
  logic           step_q;

  function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign mag_a   = cond_neg_w(opa, is_sgn & opa[W-1]);
  assign mag_b   = cond_neg_w(opb, is_sgn & opb[W-1]);
  assign mul_sum = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? opa : {W{1'b0}})};

  mdu_div_step #(.W(W)) u_div_step (
    .rem_in (rem),
    .bit_in (quo[W-1]),
    .divisor(opb),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MDU_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start) begin
            if (is_muldiv(op)) begin
              opa    <= A;
              opb    <= B;
              is_div <= (op == F_DIV) || (op == F_DIVU);
              is_sgn <= (op == F_MULT) || (op == F_DIV);
              busy   <= 1'b1;
              state  <= MDU_PREP;
            end else if (op == F_MTHI) begin
              hi <= A;
            end else if (op == F_MTLO) begin
              lo <= A;
            end
          end
        end
        // From here on opa/opb hold magnitudes; signs are carried in neg_q/neg_r
        MDU_PREP: begin
          neg_q <= is_sgn & (opa[W-1] ^ opb[W-1]);
          neg_r <= is_sgn & opa[W-1];
          dz    <= (opb == '0);
          opa   <= mag_a;
          opb   <= mag_b;
          prod  <= {{W{1'b0}}, mag_b};
          quo   <= mag_a;
          rem   <= '0;
          cnt   <= '0;
          state <= MDU_RUN;
        end
        MDU_RUN: begin
          if (is_div) begin
            rem <= step_rem;
            quo <= {quo[W-2:0], step_q};
          end else begin
            prod <= {mul_sum, prod[W-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= MDU_FIX;
        end
        // Divide by zero keeps the all-ones quotient; the remainder path already yields A
        MDU_FIX: begin
          if (is_div) begin
            lo <= cond_neg_w(quo, neg_q & ~dz);
            hi <= cond_neg_w(rem[W-1:0], neg_r);
          end else begin
            {hi, lo} <= cond_neg_2w(prod, neg_q);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: randomized and directed ops against a plain-arithmetic model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [W_OPCODE-1:0] op = '0;
  logic [W-1:0]        A = '0, B = '0;
  logic                busy, done;
  logic [W-1:0]        hi, lo;

  logic                start8 = 1'b0;
  logic [W_OPCODE-1:0] op8 = '0;
  logic [7:0]          a8 = '0, b8 = '0;
  logic                busy8, done8;
  logic [7:0]          hi8, lo8;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0, model_lo = '0;
  int busy_cnt = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Architectural result {hi,lo} from the instruction semantics, using 64-bit integers
  function automatic logic [63:0] ref_md(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    if (o == F_MULT) begin
      res = sa * sb;
    end else if (o == F_MULTU) begin
      res = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (o == F_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] r;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=1 required=0");
    end
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    if (is_muldiv(o)) begin
      r = ref_md(o, a, b);
      exp_q.push_back(r);
      model_hi = r[63:32];
      model_lo = r[31:0];
    end else if (o == F_MTHI) begin
      model_hi = a;
      check("mthi", {hi, lo}, {model_hi, model_lo});
    end else if (o == F_MTLO) begin
      model_lo = a;
      check("mtlo", {hi, lo}, {model_hi, model_lo});
    end else begin
      check("bad_op_idle", {63'b0, busy}, 64'd0);
    end
  endtask

  // Monitor: sample after the active edge, pop expectations on every done
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      busy_cnt = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_width", {63'b0, prev_done}, 64'd0);
        check("busy_len", 64'(busy_cnt), 64'(W + 2));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual hi=%h lo=%h required no done", hi, lo);
        end else begin
          check("result", {hi, lo}, exp_q.pop_front());
        end
      end
      if (busy) busy_cnt++;
      else busy_cnt = 0;
      prev_done = done;
    end
  end

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h1;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'($urandom_range(0, 255));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [5:0] ops[7];
    int n, cnt;
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, 6'h20};

    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F_MULT,  32'hFFFF_FFFD, 32'h0000_0005);
    issue(F_MULT,  32'h8000_0000, 32'h8000_0000);
    issue(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    issue(F_DIVU,  32'hFFFF_FFF9, 32'h0000_0002);
    issue(F_DIV,   32'h0000_1234, 32'h0000_0000);
    issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(F_MTHI,  32'hDEAD_BEEF, 32'h0);
    issue(F_MTLO,  32'h0000_CAFE, 32'h0);

    // Start while busy must be dropped
    issue(F_MULT, 32'h0000_0007, 32'hFFFF_FFFA);
    repeat (4) @(negedge clk);
    start = 1'b1; op = F_DIVU; A = 32'h1234_5678; B = 32'h3;
    @(negedge clk);
    start = 1'b0;
    issue(F_MTLO, 32'h0000_0001, 32'h0);

    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(0, 6)], pick(), pick());
    end

    // Reset in the middle of a divide discards it
    issue(F_DIV, 32'h7654_3210, 32'h0000_0013);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    check("midrst_hold", {hi, lo}, 64'd0);

    // Narrow instance
    start8 = 1'b1; op8 = F_MULTU; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    cnt = 0;
    while (!done8 && n < 100) begin
      if (busy8) cnt++;
      @(negedge clk);
      n++;
    end
    check("w8_done", {63'b0, done8}, 64'd1);
    check("w8_result", {48'b0, hi8, lo8}, {48'b0, 8'hFE, 8'h01});
    check("w8_busy_len", 64'(cnt), 64'd10);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
